// File: rtl/fp32_pkg.sv
// Shared constants, operand class encodings and FSM state type for the FP32
// multiplier post-multiply stage.
package fp32_pkg;

  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 23;
  localparam int FP_BIAS   = 127;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    CLS_NORM = 2'b00,
    CLS_ZERO = 2'b01,
    CLS_INF  = 2'b10,
    CLS_NAN  = 2'b11
  } cls_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/fp32_mul_norm_round_if.sv
// Operand/product capture bus and result handshake of the post-multiply stage.
// out_valid rises with a result and stays high until sampled together with
// out_ready at a clk edge; result and flags are stable while out_valid is high.
interface fp32_mul_norm_round_if;
  import fp32_pkg::*;

  logic                            sign_a;
  logic                            sign_b;
  logic [FP_EXP_W-1:0]             exp_a;
  logic [FP_EXP_W-1:0]             exp_b;
  logic [1:0]                      cls_a;
  logic [1:0]                      cls_b;
  logic [2*(FP_MANT_W+1)-1:0]      mul_prod;
  logic                            mul_ready;
  logic                            out_ready;
  logic [FP_EXP_W+FP_MANT_W:0]     result;
  logic                            out_valid;
  logic                            flag_ovf;
  logic                            flag_unf;
  logic                            flag_inx;
  logic                            flag_inv;
  logic                            busy;
  logic                            err_overrun;

  modport master (
    output sign_a, sign_b, exp_a, exp_b, cls_a, cls_b, mul_prod, mul_ready, out_ready,
    input  result, out_valid, flag_ovf, flag_unf, flag_inx, flag_inv, busy, err_overrun
  );

  modport slave (
    input  sign_a, sign_b, exp_a, exp_b, cls_a, cls_b, mul_prod, mul_ready, out_ready,
    output result, out_valid, flag_ovf, flag_unf, flag_inx, flag_inv, busy, err_overrun
  );

endinterface

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even increment of a normalised fraction given guard and
// sticky bits; carry reports a wrap of the fraction to zero.
module fp_round_rne #(
  parameter int MANT_W = 23
) (
  input  logic [MANT_W-1:0] frac,
  input  logic              g,
  input  logic              s,
  output logic [MANT_W-1:0] frac_rnd,
  output logic              carry,
  output logic              inexact
);

  logic inc;

  // Ties (g set, s clear) round up only when that makes the lsb even.
  assign inc                 = g & (s | frac[0]);
  assign {carry, frac_rnd}   = {1'b0, frac} + (MANT_W+1)'(inc);
  assign inexact             = g | s;

endmodule

// File: rtl/fp32_mul_norm_round.sv
// FP32 multiplier back end: captures the mantissa product on the rising edge of
// mul_ready, normalises, rounds (RNE), range-checks and packs a binary32 result.
module fp32_mul_norm_round
  import fp32_pkg::*;
#(
  parameter int EXP_W  = FP_EXP_W,
  parameter int MANT_W = FP_MANT_W,
  parameter int BIAS   = FP_BIAS
) (
  input  logic   clk,
  input  logic   reset,
  fp32_mul_norm_round_if.slave bus,
  output state_t dbg_state
);

  localparam int PW = 2 * (MANT_W + 1);
  localparam int EW = EXP_W + 2;
  localparam int RW = 1 + EXP_W + MANT_W;

  localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] E_MIN = '0;

  state_t state, state_nx;
  logic   rdy_d;
  logic   cap_edge;

  logic              sign_r;
  logic [EXP_W-1:0]  exp_a_r, exp_b_r;
  logic [1:0]        cls_a_r, cls_b_r;
  logic [PW-1:0]     prod_r;

  logic [EW-1:0]     e_sum, e_norm;
  logic [MANT_W-1:0] frac_norm;
  logic              g_norm, s_norm;
  logic              nan_any, inf_any, zero_any;
  logic              spec_norm, inv_norm;
  logic [RW-1:0]     spec_val_norm;

  logic [EW-1:0]     e_n;
  logic [MANT_W-1:0] frac_n;
  logic              g_n, s_n, spec_n, inv_n;
  logic [RW-1:0]     spec_val_n;

  logic [MANT_W-1:0] frac_rnd;
  logic              carry, inexact;
  logic signed [EW-1:0] e_rnd;
  logic [RW-1:0]     res_nx;
  logic              ovf_nx, unf_nx, inx_nx, inv_nx;

  assign cap_edge      = bus.mul_ready & ~rdy_d;
  assign dbg_state     = state;
  assign bus.out_valid = (state == HOLD);
  assign bus.busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      rdy_d           <= 1'b1;
      bus.err_overrun <= 1'b0;
    end else begin
      state           <= state_nx;
      rdy_d           <= bus.mul_ready;
      bus.err_overrun <= cap_edge & (state != IDLE);
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (cap_edge) state_nx = NORM;
      NORM:    state_nx = ROUND;
      ROUND:   state_nx = HOLD;
      HOLD:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && cap_edge) begin
      sign_r  <= bus.sign_a ^ bus.sign_b;
      exp_a_r <= bus.exp_a;
      exp_b_r <= bus.exp_b;
      cls_a_r <= bus.cls_a;
      cls_b_r <= bus.cls_b;
      prod_r  <= bus.mul_prod;
    end
  end

  // Exponent kept 2 bits wider than EXP_W so over/underflow stay visible as
  // signed values through rounding.
  assign e_sum  = EW'(exp_a_r) + EW'(exp_b_r) - EW'(BIAS);
  assign e_norm = prod_r[PW-1] ? e_sum + EW'(1) : e_sum;

  always_comb begin
    frac_norm = '0;
    g_norm    = 1'b0;
    s_norm    = 1'b0;
    if (prod_r[PW-1]) begin
      frac_norm = prod_r[PW-2 -: MANT_W];
      g_norm    = prod_r[PW-2-MANT_W];
      s_norm    = |prod_r[PW-3-MANT_W:0];
    end else begin
      frac_norm = prod_r[PW-3 -: MANT_W];
      g_norm    = prod_r[PW-3-MANT_W];
      s_norm    = |prod_r[PW-4-MANT_W:0];
    end
  end

  assign nan_any  = (cls_a_r == CLS_NAN)  | (cls_b_r == CLS_NAN);
  assign inf_any  = (cls_a_r == CLS_INF)  | (cls_b_r == CLS_INF);
  assign zero_any = (cls_a_r == CLS_ZERO) | (cls_b_r == CLS_ZERO);

  always_comb begin
    spec_norm     = nan_any | inf_any | zero_any;
    inv_norm      = 1'b0;
    spec_val_norm = '0;
    if (nan_any || (inf_any && zero_any)) begin
      spec_val_norm = RW'(QNAN);
      inv_norm      = inf_any & zero_any;
    end else if (inf_any) begin
      spec_val_norm = {sign_r, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    end else if (zero_any) begin
      spec_val_norm = {sign_r, {(RW-1){1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (state == NORM) begin
      e_n        <= e_norm;
      frac_n     <= frac_norm;
      g_n        <= g_norm;
      s_n        <= s_norm;
      spec_n     <= spec_norm;
      inv_n      <= inv_norm;
      spec_val_n <= spec_val_norm;
    end
  end

  fp_round_rne #(.MANT_W(MANT_W)) u_round (
    .frac     (frac_n),
    .g        (g_n),
    .s        (s_n),
    .frac_rnd (frac_rnd),
    .carry    (carry),
    .inexact  (inexact)
  );

  assign e_rnd = e_n + EW'(carry);

  always_comb begin
    res_nx = {sign_r, e_rnd[EXP_W-1:0], frac_rnd};
    ovf_nx = 1'b0;
    unf_nx = 1'b0;
    inx_nx = inexact;
    inv_nx = 1'b0;
    if (spec_n) begin
      res_nx = spec_val_n;
      inx_nx = 1'b0;
      inv_nx = inv_n;
    end else if (e_rnd >= E_MAX) begin
      res_nx = {sign_r, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      ovf_nx = 1'b1;
      inx_nx = 1'b1;
    end else if (e_rnd <= E_MIN) begin
      res_nx = {sign_r, {(RW-1){1'b0}}};
      unf_nx = 1'b1;
      inx_nx = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.result   <= '0;
      bus.flag_ovf <= 1'b0;
      bus.flag_unf <= 1'b0;
      bus.flag_inx <= 1'b0;
      bus.flag_inv <= 1'b0;
    end else if (state == ROUND) begin
      bus.result   <= res_nx;
      bus.flag_ovf <= ovf_nx;
      bus.flag_unf <= unf_nx;
      bus.flag_inx <= inx_nx;
      bus.flag_inv <= inv_nx;
    end
  end

endmodule

// File: tb/tb_fp32_mul_norm_round.sv
// Bench for fp32_mul_norm_round: directed and random products checked through
// an expected-result queue, plus hold, overrun and reset control scenarios.
module tb_fp32_mul_norm_round;
  import fp32_pkg::*;

  logic   clk = 1'b0;
  logic   reset;
  state_t dbg_state;

  fp32_mul_norm_round_if bus();

  fp32_mul_norm_round dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  logic [35:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  function automatic logic [35:0] observed();
    return {bus.flag_ovf, bus.flag_unf, bus.flag_inx, bus.flag_inv, bus.result};
  endfunction

  // Reference: {ovf,unf,inx,inv,result} from the exact product, rounding by
  // comparing the discarded remainder against one half ulp.
  function automatic logic [35:0] model_mul(input logic sa, input logic sb,
                                            input int ea, input int eb,
                                            input logic [47:0] prod);
    int          shift = prod[47] ? 24 : 23;
    int          e     = ea + eb - 127 + (prod[47] ? 1 : 0);
    logic [47:0] mant  = prod >> shift;
    logic [47:0] rem   = prod - (mant << shift);
    logic [47:0] half  = 48'd1 << (shift - 1);
    logic        sign  = sa ^ sb;
    logic        inx   = (rem != 0);
    if (rem > half || (rem == half && mant[0])) mant = mant + 48'd1;
    if (mant[24]) begin
      mant = mant >> 1;
      e++;
    end
    if (e >= 255) return {4'b1010, sign, 8'hFF, 23'h0};
    if (e <= 0)   return {4'b0110, sign, 31'h0};
    return {2'b00, inx, 1'b0, sign, 8'(e), mant[22:0]};
  endfunction

  task automatic launch(input logic sa, input logic sb, input logic [7:0] ea, input logic [7:0] eb,
                        input logic [1:0] ca, input logic [1:0] cb, input logic [47:0] prod,
                        input logic [35:0] expv, input bit push);
    bus.mul_ready = 1'b0;
    @(negedge clk);
    bus.sign_a    = sa;
    bus.sign_b    = sb;
    bus.exp_a     = ea;
    bus.exp_b     = eb;
    bus.cls_a     = ca;
    bus.cls_b     = cb;
    bus.mul_prod  = prod;
    bus.mul_ready = 1'b1;
    if (push) exp_q.push_back(expv);
    @(posedge clk);
  endtask

  // Called right after the capture edge; the capture edge counts as cycle 1.
  task automatic collect(input string tag, input bit accept);
    int          lat = 1;
    logic [35:0] e;
    @(negedge clk);
    while (!bus.out_valid && lat < 12) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, ".lat"}, 48'(lat), 48'd3);
    check({tag, ".qsize"}, 48'(exp_q.size()), 48'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(tag, 48'(observed()), 48'(e));
    end
    if (accept) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, ".drop"}, 48'(bus.out_valid), 48'd0);
    end
  endtask

  initial begin
    logic [35:0] held;
    logic [23:0] ma, mb;
    logic [7:0]  ea, eb;
    logic        sa, sb;
    logic [47:0] prod;

    reset         = 1'b1;
    bus.sign_a    = 1'b0;
    bus.sign_b    = 1'b0;
    bus.exp_a     = '0;
    bus.exp_b     = '0;
    bus.cls_a     = CLS_NORM;
    bus.cls_b     = CLS_NORM;
    bus.mul_prod  = '0;
    bus.mul_ready = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.out", 48'(observed()), 48'd0);
    check("rst.valid", 48'(bus.out_valid), 48'd0);
    check("rst.busy", 48'(bus.busy), 48'd0);
    check("rst.err", 48'(bus.err_overrun), 48'd0);
    check("rst.state", 48'(dbg_state), 48'(IDLE));
    reset = 1'b0;

    launch(0, 0, 127, 128, CLS_NORM, CLS_NORM, 48'h6000_0000_0000, {4'b0000, 32'h4040_0000}, 1);
    collect("mul_1p5x2", 1);
    launch(0, 0, 127, 127, CLS_NORM, CLS_NORM, 48'h9000_0000_0000, {4'b0000, 32'h4010_0000}, 1);
    collect("mul_1p5x1p5", 1);
    launch(0, 0, 127, 127, CLS_NORM, CLS_NORM, 48'h6000_00C0_0000, {4'b0010, 32'h3FC0_0002}, 1);
    collect("rne_tie", 1);
    launch(1, 0, 127, 127, CLS_NORM, CLS_NORM, 48'h7FFF_FFC0_0000, {4'b0010, 32'hC000_0000}, 1);
    collect("rnd_carry", 1);
    launch(0, 0, 254, 254, CLS_NORM, CLS_NORM, 48'h4000_0000_0000, {4'b1010, 32'h7F80_0000}, 1);
    collect("ovf", 1);
    launch(0, 0, 1, 1, CLS_NORM, CLS_NORM, 48'h4000_0000_0000, {4'b0110, 32'h0000_0000}, 1);
    collect("unf", 1);
    launch(0, 0, 255, 0, CLS_INF, CLS_ZERO, 48'h0, {4'b0001, QNAN}, 1);
    collect("inf_x_zero", 1);
    launch(1, 0, 0, 127, CLS_ZERO, CLS_NORM, 48'h0, {4'b0000, 32'h8000_0000}, 1);
    collect("negzero_x_norm", 1);
    launch(0, 0, 255, 127, CLS_NAN, CLS_NORM, 48'h4000_0000_0000, {4'b0000, QNAN}, 1);
    collect("nan_x_one", 1);
    launch(0, 1, 130, 255, CLS_NORM, CLS_INF, 48'h5000_0000_0000, {4'b0000, 32'hFF80_0000}, 1);
    collect("norm_x_neginf", 1);

    for (int i = 0; i < 24; i++) begin
      ma   = 24'($urandom_range(24'hFF_FFFF, 24'h80_0000));
      mb   = 24'($urandom_range(24'hFF_FFFF, 24'h80_0000));
      ea   = 8'($urandom_range(254, 1));
      eb   = 8'($urandom_range(254, 1));
      sa   = 1'($urandom_range(1, 0));
      sb   = 1'($urandom_range(1, 0));
      prod = 48'(ma) * 48'(mb);
      launch(sa, sb, ea, eb, CLS_NORM, CLS_NORM, prod, model_mul(sa, sb, int'(ea), int'(eb), prod), 1);
      collect("rand", 1);
    end

    // Back-pressure, with a stray capture edge while the result is held.
    bus.out_ready = 1'b0;
    launch(0, 0, 127, 128, CLS_NORM, CLS_NORM, 48'h6000_0000_0000, {4'b0000, 32'h4040_0000}, 1);
    collect("hold", 0);
    held = {4'b0000, 32'h4040_0000};
    bus.mul_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("hold.valid1", 48'(bus.out_valid), 48'd1);
    bus.mul_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ovr.pulse", 48'(bus.err_overrun), 48'd1);
    check("ovr.valid", 48'(bus.out_valid), 48'd1);
    @(posedge clk);
    @(negedge clk);
    check("ovr.clear", 48'(bus.err_overrun), 48'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold.valid", 48'(bus.out_valid), 48'd1);
      check("hold.data", 48'(observed()), 48'(held));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("hold.accept", 48'(bus.out_valid), 48'd0);
    check("hold.idle", 48'(dbg_state), 48'(IDLE));
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("ovr.nolaunch", 48'(bus.busy), 48'd0);

    // Reset while in ROUND, mul_ready kept high across it.
    launch(0, 0, 127, 128, CLS_NORM, CLS_NORM, 48'h6000_0000_0000, 36'h0, 0);
    @(posedge clk);
    @(negedge clk);
    check("rr.state", 48'(dbg_state), 48'(ROUND));
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rr.result", 48'(observed()), 48'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rr.valid", 48'(bus.out_valid), 48'd0);
      check("rr.busy", 48'(bus.busy), 48'd0);
    end

    check("final.qempty", 48'(exp_q.size()), 48'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
